regfile_sb: RTL and testbench

Parametrised N-read-port register file with same-cycle write bypass, synchronous clear, and a per-register pending-write scoreboard. It replaces the two-port register file in the multicycle/pipelined MIPS datapath. The control unit reserves a destination when a long-latency producer (load, multiply) issues, and uses the `busy` outputs to stall consumers until that producer writes back.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file, its scoreboard and the
// datapath/hazard logic that slices the packed read ports.
package regfile_pkg;

   localparam int unsigned REG_ZERO = 0;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned count_bits(input int unsigned max_val);
      int unsigned bits;
      bits = 1;
      while ((max_val >> bits) != 0) bits++;
      return bits;
   endfunction

   // Low bit index of port idx in a packed vector of w-bit fields.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: reservations set bits, writes clear them,
// and a registered population count tracks the number of set bits.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned REGBITS = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   regwrite,
   input  logic [REGBITS-1:0]     wa,
   input  logic                   reserve,
   input  logic [REGBITS-1:0]     resva,
   output logic [2**REGBITS-1:0]  pending,
   output logic [REGBITS:0]       pend_count
);

   localparam int unsigned NREGS = 2**REGBITS;
   localparam int unsigned CNT_W = count_bits(NREGS);
   localparam logic [REGBITS-1:0] ZERO = REGBITS'(REG_ZERO);

   logic             set_en;
   logic             clr_en;
   logic             inc;
   logic             dec;
   logic [NREGS-1:0] pending_nxt;
   logic [CNT_W-1:0] count_nxt;

   // Clear for the write first so a coincident reservation of the same register wins.
   always_comb begin
      set_en      = reserve && (resva != ZERO);
      clr_en      = regwrite && (wa != ZERO);
      inc         = set_en && !pending[resva];
      dec         = clr_en && pending[wa] && !(set_en && (resva == wa));
      pending_nxt = pending;
      if (clr_en) pending_nxt[wa] = 1'b0;
      if (set_en) pending_nxt[resva] = 1'b1;
      count_nxt   = pend_count + CNT_W'(inc) - CNT_W'(dec);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         pend_count <= '0;
      end else begin
         pending    <= pending_nxt;
         pend_count <= count_nxt;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// N-read-port register file with write bypass, r0 hardwired to zero, and a
// pending-write scoreboard driving per-port busy flags for consumer stalls.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned REGBITS = 3,
   parameter int unsigned NREAD   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       regwrite,
   input  logic [REGBITS-1:0]         wa,
   input  logic [WIDTH-1:0]           wd,
   input  logic [NREAD*REGBITS-1:0]   ra,
   output logic [NREAD*WIDTH-1:0]     rd,
   output logic [NREAD-1:0]           busy,
   input  logic                       reserve,
   input  logic [REGBITS-1:0]         resva,
   output logic [2**REGBITS-1:0]      pending,
   output logic [REGBITS:0]           pend_count
);

   localparam int unsigned NREGS = 2**REGBITS;
   localparam logic [REGBITS-1:0] ZERO = REGBITS'(REG_ZERO);

   logic [WIDTH-1:0] mem [NREGS];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= '{default: '0};
      end else if (regwrite && (wa != ZERO)) begin
         mem[wa] <= wd;
      end
   end

   regfile_scoreboard #(
      .REGBITS (REGBITS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .regwrite   (regwrite),
      .wa         (wa),
      .reserve    (reserve),
      .resva      (resva),
      .pending    (pending),
      .pend_count (pend_count)
   );

   // A same-cycle write both supplies the data and satisfies the reservation.
   for (genvar i = 0; i < NREAD; i++) begin : g_read
      logic [REGBITS-1:0] addr;
      logic               hit;

      assign addr = ra[slice_lo(i, REGBITS) +: REGBITS];
      assign hit  = regwrite && (wa == addr);

      assign rd[slice_lo(i, WIDTH) +: WIDTH] = (addr == ZERO) ? '0 :
                                               hit            ? wd : mem[addr];
      assign busy[i] = (addr != ZERO) && pending[addr] && !hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_sb;

   logic        clk;
   logic        reset;
   logic        regwrite;
   logic [2:0]  wa;
   logic [7:0]  wd;
   logic [5:0]  ra;
   logic [15:0] rd;
   logic [1:0]  busy;
   logic        reserve;
   logic [2:0]  resva;
   logic [7:0]  pending;
   logic [3:0]  pend_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_reg [8];
   logic [7:0] m_pend;

   regfile_sb #(.WIDTH(8), .REGBITS(3), .NREAD(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .regwrite   (regwrite),
      .wa         (wa),
      .wd         (wd),
      .ra         (ra),
      .rd         (rd),
      .busy       (busy),
      .reserve    (reserve),
      .resva      (resva),
      .pending    (pending),
      .pend_count (pend_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rst, input logic rw, input logic [2:0] a, input logic [7:0] d,
                        input logic [2:0] r0, input logic [2:0] r1,
                        input logic rs, input logic [2:0] rsa);
      reset = rst; regwrite = rw; wa = a; wd = d;
      ra = {r1, r0}; reserve = rs; resva = rsa;
      #1;
   endtask

   task automatic idle(input logic [2:0] r0, input logic [2:0] r1);
      drive(1'b0, 1'b0, 3'd0, 8'h00, r0, r1, 1'b0, 3'd0);
   endtask

   // Apply one clock edge to the model from the currently driven inputs.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
         m_pend = 8'h00;
      end else begin
         if (regwrite && wa != 3'd0) begin
            m_reg[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (reserve && resva != 3'd0) m_pend[resva] = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic logic [7:0] exp_rd(input logic [2:0] a);
      if (a == 3'd0) return 8'h00;
      if (regwrite && wa == a) return wd;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [2:0] a);
      return (a != 3'd0) && m_pend[a] && !(regwrite && wa == a);
   endfunction

   task automatic test_reset();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0);
      tick();
      for (int r = 0; r < 8; r++) begin
         idle(3'(r), 3'(r));
         checks++;
         if (rd !== 16'h0000 || busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_read r%0d: rd=%h busy=%b, want rd=0000 busy=00", r, rd, busy);
         end
      end
      checks++;
      if (pending !== 8'h00 || pend_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: pending=%h count=%0d, want 00/0", pending, pend_count);
      end
   endtask

   task automatic test_bypass();
      drive(1'b0, 1'b1, 3'd3, 8'h5A, 3'd3, 3'd0, 1'b0, 3'd0);
      checks++;
      if (rd[7:0] !== 8'h5A) begin
         errors++;
         $display("FAIL bypass_same_cycle: rd0=%h want 5a", rd[7:0]);
      end
      tick();
      idle(3'd3, 3'd0);
      checks++;
      if (rd[7:0] !== 8'h5A) begin
         errors++;
         $display("FAIL write_next_cycle: rd0=%h want 5a", rd[7:0]);
      end
      drive(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0, 3'd0);
      checks++;
      if (rd[7:0] !== 8'h00) begin
         errors++;
         $display("FAIL r0_bypass: rd0=%h want 00", rd[7:0]);
      end
      tick();
      idle(3'd0, 3'd0);
      checks++;
      if (rd[7:0] !== 8'h00 || pending !== 8'h00) begin
         errors++;
         $display("FAIL r0_write: rd0=%h pending=%h want 00/00", rd[7:0], pending);
      end
   endtask

   task automatic test_scoreboard();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 1'b1, 3'd5);
      checks++;
      if (busy[1] !== 1'b0 || pend_count !== 4'd0) begin
         errors++;
         $display("FAIL reserve_latency: busy1=%b count=%0d want 0/0", busy[1], pend_count);
      end
      tick();
      idle(3'd0, 3'd5);
      checks++;
      if (pending[5] !== 1'b1 || pend_count !== 4'd1 || busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL reserve_r5: pend5=%b count=%0d busy1=%b want 1/1/1", pending[5], pend_count, busy[1]);
      end
      drive(1'b0, 1'b1, 3'd5, 8'h11, 3'd0, 3'd5, 1'b0, 3'd0);
      checks++;
      if (busy[1] !== 1'b0 || rd[15:8] !== 8'h11) begin
         errors++;
         $display("FAIL write_clears_busy: busy1=%b rd1=%h want 0/11", busy[1], rd[15:8]);
      end
      tick();
      idle(3'd0, 3'd5);
      checks++;
      if (pend_count !== 4'd0 || pending !== 8'h00 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL write_clears_pend: count=%0d pending=%h busy1=%b want 0/00/0", pend_count, pending, busy[1]);
      end
   endtask

   task automatic test_same_edge();
      drive(1'b0, 1'b1, 3'd2, 8'h33, 3'd2, 3'd0, 1'b1, 3'd2);
      tick();
      idle(3'd2, 3'd2);
      checks++;
      if (rd[7:0] !== 8'h33 || pending[2] !== 1'b1 || pend_count !== 4'd1 || busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL same_reg_wr_res: rd0=%h pend2=%b count=%0d busy1=%b want 33/1/1/1",
                  rd[7:0], pending[2], pend_count, busy[1]);
      end
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd6);
      tick();
      drive(1'b0, 1'b1, 3'd6, 8'h66, 3'd6, 3'd4, 1'b1, 3'd4);
      tick();
      idle(3'd6, 3'd4);
      checks++;
      if (pend_count !== 4'd2 || pending[4] !== 1'b1 || pending[6] !== 1'b0 || rd[7:0] !== 8'h66) begin
         errors++;
         $display("FAIL diff_reg_wr_res: count=%0d pend4=%b pend6=%b rd0=%h want 2/1/0/66",
                  pend_count, pending[4], pending[6], rd[7:0]);
      end
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd0);
      tick();
      idle(3'd0, 3'd0);
      checks++;
      if (pending !== 8'h14 || pend_count !== 4'd2) begin
         errors++;
         $display("FAIL reserve_r0: pending=%h count=%0d want 14/2", pending, pend_count);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd1); tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd2); tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd7); tick();
      drive(1'b1, 1'b1, 3'd1, 8'h44, 3'd0, 3'd0, 1'b1, 3'd3); tick();
      idle(3'd1, 3'd2);
      checks++;
      if (pending !== 8'h00 || pend_count !== 4'd0 || rd !== 16'h0000 || busy !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid: pending=%h count=%0d rd=%h busy=%b want 00/0/0000/00",
                  pending, pend_count, rd, busy);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
               3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
         checks++;
         if (rd[7:0] !== exp_rd(ra[2:0]) || rd[15:8] !== exp_rd(ra[5:3]) ||
             busy[0] !== exp_busy(ra[2:0]) || busy[1] !== exp_busy(ra[5:3]) ||
             pending !== m_pend || pend_count !== 4'($countones(m_pend))) begin
            errors++;
            $display("FAIL random[%0d]: rd=%h busy=%b pending=%h count=%0d want rd=%h%h busy=%b%b pending=%h count=%0d",
                     n, rd, busy, pending, pend_count, exp_rd(ra[5:3]), exp_rd(ra[2:0]),
                     exp_busy(ra[5:3]), exp_busy(ra[2:0]), m_pend, $countones(m_pend));
         end
         tick();
      end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
      m_pend = 8'h00;
      test_reset();
      test_bypass();
      test_scoreboard();
      test_same_edge();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
